inst_fetch_queue: RTL

Instruction fetch front end sitting between the program counter/instruction memory and the instruction splitter. Holds the fetch PC, issues single-outstanding word reads to instruction memory, buffers returned instructions with their PC in a small FIFO, and presents them to the decode side with a valid/ready handshake. Branch or jump redirects from the PC adder flush the queue and discard any in-flight read.

---
 rtl/inst_fetch_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction fetch front end. It holds the fetch PC and issues word reads to
// instruction memory, with at most one read outstanding. Returned instructions
// go into a small FIFO together with their PC, and the FIFO head is presented
// to decode through a valid/ready handshake. A redirect loads a new fetch PC,
// flushes the FIFO and discards any read that is still in flight.
//
// Parameters
//   DEPTH       queue entries (power of two, >= 2)
//   RESET_PC    fetch PC loaded on reset (word address)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   imem_req     one-cycle read request strobe
//   imem_addr    word address of the request (0 when imem_req=0)
//   imem_valid   read data returned this cycle
//   imem_data    returned instruction word
//   redirect     load redirect_pc as the fetch PC and flush
//   redirect_pc  redirect target word address
//   inst_valid   queue head holds an instruction
//   inst         head instruction (0 when empty)
//   inst_pc      word address of the head instruction (0 when empty)
//   inst_ready   consumer takes the head this cycle when inst_valid=1
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("inst_fetch_queue: DEPTH must be a power of two and at least 2");
    end

    // ST_WAIT : our own read is outstanding, its data will be queued.
    // ST_FLUSH: a read issued before a redirect is outstanding, its data is dropped.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [31:0]        fetch_pc;

    logic [31:0]        mem_inst [DEPTH];
    logic [31:0]        mem_pc   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               full;
    logic               req;
    logic               push;
    logic               pop;

    // ------------------------------------------------------------------
    // Next-state, request and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req        = 1'b0;
        push       = 1'b0;

        full       = (count == FULL_CNT);
        inst_valid = (count != '0);
        pop        = inst_valid & inst_ready;

        case (state)
            ST_FETCH: begin
                // Requests only go out with a free slot, so a response
                // can never land in a full queue.
                if (!redirect && !full) begin
                    req        = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_valid) begin
                    push       = !redirect;
                    state_next = ST_FETCH;
                end else if (redirect) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (imem_valid) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // Held low while reset is asserted even though the state register
        // already reads FETCH with an empty queue.
        imem_req  = req & rst_n;
        imem_addr = imem_req ? fetch_pc : '0;

        inst      = inst_valid ? mem_inst[rd_ptr] : '0;
        inst_pc   = inst_valid ? mem_pc[rd_ptr]   : '0;
    end

    // ------------------------------------------------------------------
    // Control state and fetch PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mem_inst <= '{default: '0};
            mem_pc   <= '{default: '0};
        end else if (redirect) begin
            // Any pop in this cycle is irrelevant: the queue is emptied.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_inst[wr_ptr] <= imem_data;
                mem_pc[wr_ptr]   <= fetch_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule
